// File: rtl/fir_param_filter_if.sv
// Sample, coefficient and result signals of fir_param_filter, bundled for port connection.
// The master side is the sample/coefficient source; the slave side is the filter.
interface fir_param_filter_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 9,
    parameter int OUT_W  = 20
);
    localparam int AW = $clog2(TAPS);

    logic                     clr;
    logic                     in_valid;
    logic signed [DATA_W-1:0] FIR_IN;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_din;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  FIR_OUT;
    logic                     ovf;

    modport master (
        output clr, in_valid, FIR_IN, coef_we, coef_addr, coef_din,
        input  out_valid, FIR_OUT, ovf
    );

    modport slave (
        input  clr, in_valid, FIR_IN, coef_we, coef_addr, coef_din,
        output out_valid, FIR_OUT, ovf
    );
endinterface

// File: rtl/fir_param_filter.sv
// Pipelined signed direct-form FIR: delay line -> registered products -> summed, rounded,
// saturated result. Coefficients are runtime-loadable; clr flushes history and valids.
module fir_param_filter #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 9,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = 20
) (
    input logic                CLK,
    input logic                RSTn,
    fir_param_filter_if.slave  fir_io
);
    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + AW;
    // One spare bit so the rounding add can never wrap.
    localparam int SW    = ACC_W + 1;

    localparam logic signed [SW-1:0] One  = SW'(1);
    localparam logic signed [SW-1:0] MaxV = (One <<< (OUT_W - 1)) - One;
    localparam logic signed [SW-1:0] MinV = -MaxV - One;

    logic signed [DATA_W-1:0] d_q [TAPS];
    logic signed [DATA_W-1:0] d_d [TAPS];
    logic signed [COEF_W-1:0] c_q [TAPS];
    logic signed [COEF_W-1:0] c_d [TAPS];
    logic signed [PW-1:0]     p_q [TAPS];
    logic signed [PW-1:0]     p_d [TAPS];

    logic                    v1_q, v1_d;
    logic                    v2_q, v2_d;
    logic                    ov_q, ov_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] acc;
    logic signed [SW-1:0]    rnd_k;
    logic signed [SW-1:0]    rnd;
    logic signed [SW-1:0]    shf;

    if (SHIFT > 0) begin : g_round
        assign rnd_k = One <<< (SHIFT - 1);
    end else begin : g_no_round
        assign rnd_k = '0;
    end

    always_comb begin
        d_d = d_q;
        if (fir_io.clr) begin
            for (int i = 0; i < TAPS; i++) d_d[i] = '0;
        end else if (fir_io.in_valid) begin
            d_d[0] = fir_io.FIR_IN;
            for (int i = 1; i < TAPS; i++) d_d[i] = d_q[i-1];
        end
    end

    // Out-of-range addresses are dropped; clr does not block a write.
    always_comb begin
        c_d = c_q;
        if (fir_io.coef_we && ({1'b0, fir_io.coef_addr} < (AW + 1)'(TAPS))) begin
            c_d[fir_io.coef_addr] = fir_io.coef_din;
        end
    end

    always_comb begin
        for (int i = 0; i < TAPS; i++) p_d[i] = PW'(d_q[i]) * PW'(c_q[i]);
    end

    always_comb begin
        v1_d = fir_io.in_valid & ~fir_io.clr;
        v2_d = v1_q & ~fir_io.clr;
        ov_d = v2_q & ~fir_io.clr;
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < TAPS; i++) acc = acc + ACC_W'(p_q[i]);
        rnd = SW'(acc) + rnd_k;
        shf = rnd >>> SHIFT;
    end

    // Result register only moves when a valid result lands and no flush is pending.
    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        if (v2_q && !fir_io.clr) begin
            if (shf > MaxV) begin
                out_d = MaxV[OUT_W-1:0];
                ovf_d = 1'b1;
            end else if (shf < MinV) begin
                out_d = MinV[OUT_W-1:0];
                ovf_d = 1'b1;
            end else begin
                out_d = shf[OUT_W-1:0];
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < TAPS; i++) begin
                d_q[i] <= '0;
                c_q[i] <= '0;
                p_q[i] <= '0;
            end
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            ov_q  <= 1'b0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            d_q   <= d_d;
            c_q   <= c_d;
            p_q   <= p_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            ov_q  <= ov_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign fir_io.out_valid = ov_q;
    assign fir_io.FIR_OUT   = out_q;
    assign fir_io.ovf       = ovf_q;

endmodule

// File: tb/tb_fir_param_filter.sv
// Scoreboard bench for fir_param_filter: three instances (default, 16-bit saturating,
// shift-by-2 rounding) driven with directed vectors; a monitor checks value, ovf and arrival cycle.
module tb_fir_param_filter;
    logic CLK  = 1'b0;
    logic RSTn = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic              in_valid  [3];
    logic              coef_we   [3];
    logic              clr       [3];
    logic signed [7:0] fir_in    [3];
    logic signed [7:0] coef_din  [3];
    logic [3:0]        coef_addr [3];

    logic               ov    [3];
    logic               ovf_s [3];
    logic signed [31:0] fo    [3];

    fir_param_filter_if #(.DATA_W(8), .COEF_W(8), .TAPS(9), .OUT_W(20)) ifa ();
    fir_param_filter_if #(.DATA_W(8), .COEF_W(8), .TAPS(9), .OUT_W(16)) ifb ();
    fir_param_filter_if #(.DATA_W(8), .COEF_W(8), .TAPS(9), .OUT_W(18)) ifc ();

    assign ifa.clr = clr[0];  assign ifa.in_valid = in_valid[0];  assign ifa.FIR_IN = fir_in[0];
    assign ifa.coef_we = coef_we[0];  assign ifa.coef_addr = coef_addr[0];
    assign ifa.coef_din = coef_din[0];
    assign ifb.clr = clr[1];  assign ifb.in_valid = in_valid[1];  assign ifb.FIR_IN = fir_in[1];
    assign ifb.coef_we = coef_we[1];  assign ifb.coef_addr = coef_addr[1];
    assign ifb.coef_din = coef_din[1];
    assign ifc.clr = clr[2];  assign ifc.in_valid = in_valid[2];  assign ifc.FIR_IN = fir_in[2];
    assign ifc.coef_we = coef_we[2];  assign ifc.coef_addr = coef_addr[2];
    assign ifc.coef_din = coef_din[2];

    assign ov[0] = ifa.out_valid;  assign ovf_s[0] = ifa.ovf;  assign fo[0] = 32'(ifa.FIR_OUT);
    assign ov[1] = ifb.out_valid;  assign ovf_s[1] = ifb.ovf;  assign fo[1] = 32'(ifb.FIR_OUT);
    assign ov[2] = ifc.out_valid;  assign ovf_s[2] = ifc.ovf;  assign fo[2] = 32'(ifc.FIR_OUT);

    fir_param_filter #(.DATA_W(8), .COEF_W(8), .TAPS(9), .SHIFT(0), .OUT_W(20)) u_a (
        .CLK(CLK), .RSTn(RSTn), .fir_io(ifa.slave)
    );
    fir_param_filter #(.DATA_W(8), .COEF_W(8), .TAPS(9), .SHIFT(0), .OUT_W(16)) u_b (
        .CLK(CLK), .RSTn(RSTn), .fir_io(ifb.slave)
    );
    fir_param_filter #(.DATA_W(8), .COEF_W(8), .TAPS(9), .SHIFT(2), .OUT_W(18)) u_c (
        .CLK(CLK), .RSTn(RSTn), .fir_io(ifc.slave)
    );

    typedef struct {
        int val;
        bit o;
        int at;
    } exp_t;

    exp_t exp_q [3][$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RSTn) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("dut%0d spurious out_valid", i), 1, 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("dut%0d FIR_OUT", i), fo[i], e.val);
                        chk($sformatf("dut%0d ovf", i), 32'(ovf_s[i]), 32'(e.o));
                        chk($sformatf("dut%0d arrival cycle", i), cyc, e.at);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    // Valid sample; result expected three cycles later.
    task automatic samp(input int id, input int din, input int ev, input bit eo);
        in_valid[id] = 1'b1;
        fir_in[id]   = 8'(din);
        exp_q[id].push_back('{val: ev, o: eo, at: cyc + 3});
        tick();
        in_valid[id] = 1'b0;
    endtask

    task automatic wc(input int id, input int addr, input int val);
        coef_we[id]   = 1'b1;
        coef_addr[id] = 4'(addr);
        coef_din[id]  = 8'(val);
        tick();
        coef_we[id]   = 1'b0;
    endtask

    task automatic drain(input int id);
        int n = 0;
        while (exp_q[id].size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("dut%0d results outstanding", id), exp_q[id].size(), 0);
    endtask

    // npop: samples still in the valid pipeline that the flush discards.
    task automatic clr_pulse(input int id, input int npop, input int held, input bit heldo);
        exp_t t;
        clr[id]      = 1'b1;
        in_valid[id] = 1'b1;
        fir_in[id]   = 8'sd10;
        for (int k = 0; k < npop; k++) t = exp_q[id].pop_back();
        tick();
        clr[id]      = 1'b0;
        in_valid[id] = 1'b0;
        chk($sformatf("dut%0d out_valid after clr", id), 32'(ov[id]), 0);
        chk($sformatf("dut%0d FIR_OUT held over clr", id), fo[id], held);
        chk($sformatf("dut%0d ovf held over clr", id), 32'(ovf_s[id]), 32'(heldo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;  coef_we[i] = 1'b0;  clr[i] = 1'b0;
            fir_in[i] = '0;  coef_din[i] = '0;  coef_addr[i] = '0;
        end
        #1 RSTn = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d reset out_valid", i), 32'(ov[i]), 0);
            chk($sformatf("dut%0d reset FIR_OUT", i), fo[i], 0);
            chk($sformatf("dut%0d reset ovf", i), 32'(ovf_s[i]), 0);
        end
        RSTn = 1'b1;
        tick();

        // Impulse through c = 1..9; out-of-range writes must not land anywhere.
        for (int i = 0; i < 9; i++) wc(0, i, i + 1);
        wc(0, 15, -50);
        wc(0, 9, 77);
        samp(0, 1, 1, 1'b0);
        for (int k = 2; k <= 9; k++) samp(0, 0, k, 1'b0);
        for (int k = 0; k < 12; k++) samp(0, 0, 0, 1'b0);
        drain(0);

        // Gapped impulse: arrival cycles must reproduce the gaps.
        samp(0, 1, 1, 1'b0);
        tick();
        for (int k = 2; k <= 9; k++) begin
            samp(0, 0, k, 1'b0);
            tick();
        end
        samp(0, 0, 0, 1'b0);
        drain(0);

        // DC 10 with all c = 1 ramps to 90; live write c[4] = -1 steps straight to 70.
        for (int i = 0; i < 9; i++) wc(0, i, 1);
        for (int k = 1; k <= 9; k++) samp(0, 10, 10 * k, 1'b0);
        for (int k = 0; k < 3; k++) samp(0, 10, 90, 1'b0);
        coef_we[0] = 1'b1;  coef_addr[0] = 4'd4;  coef_din[0] = -8'sd1;
        samp(0, 10, 70, 1'b0);
        coef_we[0] = 1'b0;
        for (int k = 0; k < 4; k++) samp(0, 10, 70, 1'b0);
        drain(0);

        // clr mid-stream: history refills from zero, coefficients kept.
        wc(0, 4, 1);
        for (int k = 0; k < 5; k++) samp(0, 10, 90, 1'b0);
        clr_pulse(0, 2, 90, 1'b0);
        for (int k = 1; k <= 9; k++) samp(0, 10, 10 * k, 1'b0);
        for (int k = 0; k < 2; k++) samp(0, 10, 90, 1'b0);
        drain(0);

        // Positive then negative saturation at OUT_W = 16.
        for (int i = 0; i < 9; i++) wc(1, i, -128);
        samp(1, -128, 16384, 1'b0);
        for (int k = 0; k < 10; k++) samp(1, -128, 32767, 1'b1);
        drain(1);
        repeat (3) tick();
        clr_pulse(1, 0, 32767, 1'b1);
        samp(1, 127, -16256, 1'b0);
        samp(1, 127, -32512, 1'b0);
        for (int k = 0; k < 8; k++) samp(1, 127, -32768, 1'b1);
        drain(1);

        // Round half up then arithmetic shift by 2, single tap c[0] = 1.
        wc(2, 0, 1);
        samp(2, 6, 2, 1'b0);
        samp(2, 5, 1, 1'b0);
        samp(2, -6, -1, 1'b0);
        samp(2, -7, -2, 1'b0);
        samp(2, 2, 1, 1'b0);
        samp(2, -2, 0, 1'b0);
        samp(2, 1, 0, 1'b0);
        samp(2, 3, 1, 1'b0);
        samp(2, 127, 32, 1'b0);
        drain(2);

        // Asynchronous reset mid-stream, then no coefficient reload.
        for (int k = 0; k < 4; k++) samp(0, 10, 90, 1'b0);
        in_valid[0] = 1'b1;
        fir_in[0]   = 8'sd10;
        #2 RSTn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d async reset out_valid", i), 32'(ov[i]), 0);
            chk($sformatf("dut%0d async reset FIR_OUT", i), fo[i], 0);
            chk($sformatf("dut%0d async reset ovf", i), 32'(ovf_s[i]), 0);
            exp_q[i].delete();
        end
        in_valid[0] = 1'b0;
        tick();
        RSTn = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) samp(0, 10, 0, 1'b0);
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
